// File: rtl/fsm_pkg.sv
// ============================================================================
// fsm_pkg : shared state encoding and counter sizing for the PISO serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package fsm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit counter width; a 1-bit floor keeps the counter declarable for tiny words
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_bit_serializer_shift_reg.sv
// ============================================================================
// bit_shift_reg : WIDTH-bit loadable shift register, direction set by MSB_FIRST
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_first_bit,
  output logic             o_head
);

  logic [WIDTH-1:0] r_q;

  // The first bit of a word goes straight to the output flop in the top
  // level, so the register stores the word already advanced by one position
  // and o_head is always the bit that goes out next.
  generate
    if (MSB_FIRST) begin : g_msb
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (i_load) begin
          r_q <= {i_data[WIDTH-2:0], 1'b0};
        end else if (i_shift) begin
          r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
      end
      assign o_first_bit = i_data[WIDTH-1];
      assign o_head      = r_q[WIDTH-1];
    end else begin : g_lsb
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (i_load) begin
          r_q <= {1'b0, i_data[WIDTH-1:1]};
        end else if (i_shift) begin
          r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
      end
      assign o_first_bit = i_data[0];
      assign o_head      = r_q[0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/piso_bit_serializer.sv
// ============================================================================
// piso_bit_serializer : valid/ready word in, one registered bit per clock out
// Rev 1.0
// ============================================================================
`default_nettype none

module piso_bit_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;
  logic             w_xfer, w_load, w_shift, w_first_bit, w_head;
  logic [WIDTH-1:0] w_load_data;

  assign w_xfer = din_valid && !r_hold_full;

  bit_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_data      (w_load_data),
    .o_first_bit (w_first_bit),
    .o_head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hold_nxt       = r_hold;
    w_hold_full_nxt  = r_hold_full;
    w_load           = 1'b0;
    w_shift          = 1'b0;
    w_load_data      = din;
    w_dout_nxt       = IDLE_BIT;
    w_dout_valid_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt != CNT_LAST) begin
          w_shift   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_xfer) begin
            w_hold_nxt      = din;
            w_hold_full_nxt = 1'b1;
          end
        // Last bit: reload from the hold, else bypass a fresh word, else stop
        end else if (r_hold_full) begin
          w_load          = 1'b1;
          w_load_data     = r_hold;
          w_hold_full_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end else if (w_xfer) begin
          w_load    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_dout_valid_nxt = w_load || w_shift;
    if (w_load) begin
      w_dout_nxt = w_first_bit;
    end else if (w_shift) begin
      w_dout_nxt = w_head;
    end
  end

  assign din_ready  = !r_hold_full;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == ST_SHIFT) || r_hold_full;

endmodule

`default_nettype wire
